// File: rtl/dmem_if.sv
// Load/store bus between the core (master) and the data-memory responder (slave),
// including the console FIFO drain handshake.
interface dmem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int CNT_W  = 16
);
    logic              wr;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [2:0]        funct3;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              misalign_err;
    logic [CNT_W-1:0]  wr_count;
    logic [CNT_W-1:0]  rd_count;
    logic [7:0]        con_data;
    logic              con_valid;
    logic              con_ready;

    modport master (
        output wr, rd, addr, wr_data, funct3, con_ready,
        input  rd_data, rd_valid, misalign_err, wr_count, rd_count, con_data, con_valid
    );

    modport slave (
        input  wr, rd, addr, wr_data, funct3, con_ready,
        output rd_data, rd_valid, misalign_err, wr_count, rd_count, con_data, con_valid
    );
endinterface

// File: rtl/dmem_responder.sv
// Byte-addressed data memory with registered, size-extended loads, misalignment
// flagging and access counters. DMEM_CONSOLE_EN maps a console FIFO at the top word.
module dmem_responder #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 9,
    parameter int CNT_W     = 16,
    parameter int CON_DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset,
    dmem_if.slave  bus
);
    localparam int WORDS = 2 ** (ADDR_W - 2);

    logic [DATA_W-1:0] mem_q [WORDS];
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              misalign_q;
    logic [CNT_W-1:0]  wr_count_q;
    logic [CNT_W-1:0]  rd_count_q;

    logic [1:0]        lane_s;
    logic [ADDR_W-3:0] widx_s;
    logic              aligned_s;
    logic [3:0]        be_s;
    logic [DATA_W-1:0] wlane_s;
    logic [DATA_W-1:0] rword_s;
    logic [DATA_W-1:0] shifted_s;
    logic [DATA_W-1:0] rresult_s;
    logic              st_ok_s;
    logic              ld_ok_s;
    logic              mem_we_s;

    assign lane_s  = bus.addr[1:0];
    assign widx_s  = bus.addr[ADDR_W-1:2];
    assign st_ok_s = bus.wr & aligned_s;
    assign ld_ok_s = bus.rd & aligned_s;

`ifdef DMEM_CONSOLE_EN
    localparam int PW = $clog2(CON_DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    fifo_q [CON_DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] cnt_q;
    logic          ovf_q;
    logic          con_hit_s;
    logic          con_valid_s;
    logic          full_s;
    logic          push_req_s;
    logic          push_s;
    logic          pop_s;
    logic          drop_s;
    logic [7:0]    cnt8_s;

    assign con_hit_s   = &widx_s;
    assign con_valid_s = (cnt_q != {CW{1'b0}});
    assign full_s      = (cnt_q == CW'(CON_DEPTH));
    assign pop_s       = con_valid_s & bus.con_ready;
    assign push_req_s  = st_ok_s & con_hit_s;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_s      = push_req_s & (~full_s | pop_s);
    assign drop_s      = push_req_s & full_s & ~pop_s;
    assign mem_we_s    = st_ok_s & ~con_hit_s;
    assign cnt8_s      = 8'(cnt_q);
    assign rword_s     = con_hit_s ? {{(DATA_W-9){1'b0}}, ovf_q, cnt8_s} : mem_q[widx_s];
    assign bus.con_valid = con_valid_s;
    assign bus.con_data  = con_valid_s ? fifo_q[head_q] : 8'h00;
`else
    logic unused_con_ready_s;

    assign unused_con_ready_s = bus.con_ready;
    assign mem_we_s      = st_ok_s;
    assign rword_s       = mem_q[widx_s];
    assign bus.con_valid = 1'b0;
    assign bus.con_data  = 8'h00;
`endif

    // Size/alignment decode, byte enables and lane replication of store data.
    always_comb begin
        aligned_s = 1'b0;
        be_s      = 4'b0000;
        wlane_s   = {DATA_W{1'b0}};
        case (bus.funct3)
            3'b000, 3'b100: begin
                aligned_s = 1'b1;
                be_s      = 4'b0001 << lane_s;
                wlane_s   = {4{bus.wr_data[7:0]}};
            end
            3'b001, 3'b101: begin
                aligned_s = ~bus.addr[0];
                be_s      = bus.addr[1] ? 4'b1100 : 4'b0011;
                wlane_s   = {2{bus.wr_data[15:0]}};
            end
            3'b010: begin
                aligned_s = (lane_s == 2'b00);
                be_s      = 4'b1111;
                wlane_s   = bus.wr_data;
            end
            default: begin
                aligned_s = 1'b0;
                be_s      = 4'b0000;
                wlane_s   = {DATA_W{1'b0}};
            end
        endcase
    end

    // Load extraction: shift addressed lane to bit 0 and extend by size code.
    always_comb begin
        shifted_s = rword_s >> {lane_s, 3'b000};
        rresult_s = {DATA_W{1'b0}};
        if (aligned_s) begin
            case (bus.funct3)
                3'b000:  rresult_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
                3'b100:  rresult_s = {24'h000000, shifted_s[7:0]};
                3'b001:  rresult_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
                3'b101:  rresult_s = {16'h0000, shifted_s[15:0]};
                3'b010:  rresult_s = shifted_s;
                default: rresult_s = {DATA_W{1'b0}};
            endcase
        end else begin
            rresult_s = {DATA_W{1'b0}};
        end
    end

    // Memory array write port; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_q[widx_s][8*b +: 8] <= wlane_s[8*b +: 8];
                end
            end
        end
    end

    // Load response, sticky error, counters and console FIFO state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q  <= {DATA_W{1'b0}};
            rd_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            wr_count_q <= {CNT_W{1'b0}};
            rd_count_q <= {CNT_W{1'b0}};
`ifdef DMEM_CONSOLE_EN
            for (int i = 0; i < CON_DEPTH; i++) begin
                fifo_q[i] <= 8'h00;
            end
            head_q <= {PW{1'b0}};
            tail_q <= {PW{1'b0}};
            cnt_q  <= {CW{1'b0}};
            ovf_q  <= 1'b0;
`endif
        end else begin
            rd_valid_q <= bus.rd;
            if (bus.rd) begin
                rd_data_q <= rresult_s;
            end
            if ((bus.wr | bus.rd) & ~aligned_s) begin
                misalign_q <= 1'b1;
            end
            if (st_ok_s) begin
                wr_count_q <= wr_count_q + CNT_W'(1'b1);
            end
            if (ld_ok_s) begin
                rd_count_q <= rd_count_q + CNT_W'(1'b1);
            end
`ifdef DMEM_CONSOLE_EN
            if (push_s) begin
                fifo_q[tail_q] <= bus.wr_data[7:0];
                tail_q         <= tail_q + PW'(1'b1);
            end
            if (pop_s) begin
                head_q <= head_q + PW'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   cnt_q <= cnt_q + CW'(1'b1);
                2'b01:   cnt_q <= cnt_q - CW'(1'b1);
                default: cnt_q <= cnt_q;
            endcase
            if (drop_s) begin
                ovf_q <= 1'b1;
            end
`endif
        end
    end

    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.misalign_err = misalign_q;
    assign bus.wr_count     = wr_count_q;
    assign bus.rd_count     = rd_count_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder; console steps run when DMEM_CONSOLE_EN is defined.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    dmem_if bus ();

    dmem_responder u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic w, input logic r, input logic [8:0] a,
                       input logic [2:0] f, input logic [31:0] d);
        bus.wr      = w;
        bus.rd      = r;
        bus.addr    = a;
        bus.funct3  = f;
        bus.wr_data = d;
        cyc();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_data"},  bus.rd_data, 32'h0);
        chk({tag, "_rd_valid"}, {31'h0, bus.rd_valid}, 32'h0);
        chk({tag, "_misalign"}, {31'h0, bus.misalign_err}, 32'h0);
        chk({tag, "_wr_count"}, {16'h0, bus.wr_count}, 32'h0);
        chk({tag, "_rd_count"}, {16'h0, bus.rd_count}, 32'h0);
        chk({tag, "_con_valid"}, {31'h0, bus.con_valid}, 32'h0);
        chk({tag, "_con_data"}, {24'h0, bus.con_data}, 32'h0);
    endtask

    initial begin
        bus.wr = 1'b0; bus.rd = 1'b0; bus.addr = 9'h000; bus.wr_data = 32'h0;
        bus.funct3 = 3'b000; bus.con_ready = 1'b0;
        reset = 1'b0;
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // sw then back-to-back lb / lbu / lh / lw
        req(1'b1, 1'b0, 9'h010, 3'b010, 32'h8000_00F0);
        req(1'b0, 1'b1, 9'h010, 3'b000, 32'h0);
        chk("lb", bus.rd_data, 32'hFFFF_FFF0);
        chk("lb_valid", {31'h0, bus.rd_valid}, 32'h1);
        req(1'b0, 1'b1, 9'h010, 3'b100, 32'h0);
        chk("lbu", bus.rd_data, 32'h0000_00F0);
        chk("lbu_valid", {31'h0, bus.rd_valid}, 32'h1);
        req(1'b0, 1'b1, 9'h012, 3'b001, 32'h0);
        chk("lh", bus.rd_data, 32'hFFFF_8000);
        req(1'b0, 1'b1, 9'h010, 3'b010, 32'h0);
        chk("lw", bus.rd_data, 32'h8000_00F0);
        chk("lw_valid", {31'h0, bus.rd_valid}, 32'h1);
        bus.rd = 1'b0;
        cyc();
        chk("idle_valid", {31'h0, bus.rd_valid}, 32'h0);
        chk("idle_hold", bus.rd_data, 32'h8000_00F0);
        chk("rd_count4", {16'h0, bus.rd_count}, 32'd4);
        chk("wr_count1", {16'h0, bus.wr_count}, 32'd1);

        // byte store into a word, then sub-word loads
        req(1'b1, 1'b0, 9'h020, 3'b010, 32'h1122_3344);
        req(1'b1, 1'b0, 9'h021, 3'b000, 32'hFFFF_FFAB);
        req(1'b0, 1'b1, 9'h020, 3'b010, 32'h0);
        chk("sb_merge", bus.rd_data, 32'h1122_AB44);
        req(1'b0, 1'b1, 9'h022, 3'b101, 32'h0);
        chk("lhu_hi", bus.rd_data, 32'h0000_1122);
        req(1'b0, 1'b1, 9'h020, 3'b001, 32'h0);
        chk("lh_neg", bus.rd_data, 32'hFFFF_AB44);

        // same-cycle store and load: read-before-write
        req(1'b1, 1'b0, 9'h030, 3'b010, 32'h0000_0005);
        req(1'b1, 1'b1, 9'h030, 3'b010, 32'hDEAD_BEEF);
        chk("rbw_old", bus.rd_data, 32'h0000_0005);
        chk("rbw_wr_count", {16'h0, bus.wr_count}, 32'd5);
        chk("rbw_rd_count", {16'h0, bus.rd_count}, 32'd8);
        req(1'b0, 1'b1, 9'h030, 3'b010, 32'h0);
        chk("rbw_new", bus.rd_data, 32'hDEAD_BEEF);
        chk("misalign_clear", {31'h0, bus.misalign_err}, 32'h0);

        // misaligned and illegal accesses
        req(1'b0, 1'b1, 9'h006, 3'b010, 32'h0);
        chk("mis_lw_valid", {31'h0, bus.rd_valid}, 32'h1);
        chk("mis_lw_data", bus.rd_data, 32'h0);
        chk("mis_lw_flag", {31'h0, bus.misalign_err}, 32'h1);
        chk("mis_lw_rd_count", {16'h0, bus.rd_count}, 32'd9);
        req(1'b1, 1'b0, 9'h031, 3'b001, 32'h0000_FFFF);
        chk("mis_sh_wr_count", {16'h0, bus.wr_count}, 32'd5);
        chk("mis_sticky", {31'h0, bus.misalign_err}, 32'h1);
        req(1'b0, 1'b1, 9'h030, 3'b010, 32'h0);
        chk("mis_sh_mem", bus.rd_data, 32'hDEAD_BEEF);
        req(1'b0, 1'b1, 9'h000, 3'b011, 32'h0);
        chk("illegal_valid", {31'h0, bus.rd_valid}, 32'h1);
        chk("illegal_data", bus.rd_data, 32'h0);
        chk("illegal_rd_count", {16'h0, bus.rd_count}, 32'd10);

`ifndef DMEM_CONSOLE_EN
        // top word is ordinary memory in this build
        req(1'b1, 1'b0, 9'h1FC, 3'b010, 32'h0);
        req(1'b1, 1'b0, 9'h1FF, 3'b000, 32'h0000_005A);
        req(1'b0, 1'b1, 9'h1FC, 3'b010, 32'h0);
        chk("top_word_mem", bus.rd_data, 32'h5A00_0000);
        bus.con_ready = 1'b1;
        bus.rd = 1'b0;
        cyc();
        chk("no_con_valid", {31'h0, bus.con_valid}, 32'h0);
        chk("no_con_data", {24'h0, bus.con_data}, 32'h0);
        bus.con_ready = 1'b0;
`else
        bus.wr = 1'b0; bus.rd = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        reset = 1'b1;
        req(1'b1, 1'b0, 9'h1FC, 3'b000, 32'h48);
        req(1'b1, 1'b0, 9'h1FC, 3'b000, 32'h65);
        req(1'b1, 1'b0, 9'h1FC, 3'b000, 32'h6C);
        req(1'b1, 1'b0, 9'h1FC, 3'b000, 32'h6C);
        chk("con_valid_fill", {31'h0, bus.con_valid}, 32'h1);
        chk("con_head_H", {24'h0, bus.con_data}, 32'h48);
        req(1'b1, 1'b0, 9'h1FC, 3'b000, 32'h6F);
        req(1'b0, 1'b1, 9'h1FC, 3'b010, 32'h0);
        chk("con_status", bus.rd_data, 32'h0000_0104);
        chk("con_no_misalign", {31'h0, bus.misalign_err}, 32'h0);
        bus.rd = 1'b0;
        bus.con_ready = 1'b1;
        chk("drain_0", {24'h0, bus.con_data}, 32'h48);
        cyc();
        chk("drain_1", {24'h0, bus.con_data}, 32'h65);
        cyc();
        chk("drain_2", {24'h0, bus.con_data}, 32'h6C);
        cyc();
        chk("drain_3", {24'h0, bus.con_data}, 32'h6C);
        cyc();
        chk("drain_empty", {31'h0, bus.con_valid}, 32'h0);
        chk("drain_empty_data", {24'h0, bus.con_data}, 32'h0);
        bus.con_ready = 1'b0;
        req(1'b1, 1'b0, 9'h1FC, 3'b000, 32'h5A);
        req(1'b1, 1'b0, 9'h1FC, 3'b000, 32'h31);
        req(1'b1, 1'b0, 9'h1FC, 3'b000, 32'h32);
        req(1'b1, 1'b0, 9'h1FC, 3'b000, 32'h33);
        bus.con_ready = 1'b1;
        req(1'b1, 1'b0, 9'h1FC, 3'b010, 32'h34);
        bus.con_ready = 1'b0;
        chk("full_pushpop_head", {24'h0, bus.con_data}, 32'h31);
        req(1'b0, 1'b1, 9'h1FC, 3'b010, 32'h0);
        chk("full_pushpop_status", bus.rd_data, 32'h0000_0104);
`endif

        // asynchronous reset in the middle of a cycle
        bus.wr = 1'b0; bus.rd = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk_all_zero("async_reset");
        reset = 1'b1;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
